motor_drive: RTL and testbench

Downstream stage of the steering logic. Consumes the 8-bit navigation pattern (proceed / turn left / turn right / stop) and the travel-direction switch, and drives two DC-motor channels with PWM and direction pins. Duty is soft-ramped toward a per-command target. A direction change always brakes to zero duty and waits a dead time before the direction pins flip.

---
 rtl/motor_drive_pkg.sv | 21 ++
 rtl/motor_drive_if.sv | 30 +++
 rtl/motor_ramp_pwm.sv | 57 +++++
 rtl/motor_drive.sv | 155 +++++++++++++++
 tb/tb_motor_drive.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/motor_drive_pkg.sv
// motor_drive_pkg: shared definitions for the motor drive stage.
//   - navigation pattern encodings produced by the steering logic
//   - direction pin levels
//   - drive FSM state type
package motor_drive_pkg;

  localparam logic [7:0] NAV_PROCEED = 8'hFF;
  localparam logic [7:0] NAV_LEFT    = 8'hF0;
  localparam logic [7:0] NAV_RIGHT   = 8'h0F;
  localparam logic [7:0] NAV_STOP    = 8'h00;

  localparam logic FWD = 1'b1;
  localparam logic REV = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BRAKE = 2'd1,
    ST_DEAD  = 2'd2
  } drive_state_e;

endpackage

// File: rtl/motor_drive_if.sv
// motor_drive_if: steering-to-motor bundle.
//   nav      steering pattern (proceed / left / right / stop)
//   dir_fwd  travel direction switch, 1 = forward
//   pwm_l/r  motor PWM
//   dir_l/r  motor direction pins, 1 = forward
//   moving   either applied duty non-zero
//   braking  drive is braking or waiting out the dead time
// master: steering side, slave: motor_drive.
interface motor_drive_if;

  logic [7:0] nav;
  logic       dir_fwd;
  logic       pwm_l;
  logic       pwm_r;
  logic       dir_l;
  logic       dir_r;
  logic       moving;
  logic       braking;

  modport master (
    output nav, dir_fwd,
    input  pwm_l, pwm_r, dir_l, dir_r, moving, braking
  );

  modport slave (
    input  nav, dir_fwd,
    output pwm_l, pwm_r, dir_l, dir_r, moving, braking
  );

endinterface

// File: rtl/motor_ramp_pwm.sv
// motor_ramp_pwm: one motor channel.
// Ramps its duty toward the target by RAMP_STEP on each tick (saturating
// at the target), shadows it into the applied duty at the start of each
// PWM period, and produces a registered PWM output.
//   clk, rst_n    clock, synchronous active-low reset
//   target        duty the ramp is heading for
//   tick          one-cycle ramp strobe
//   pwm_cnt       shared free-running PWM counter
//   ramp_duty     current ramp duty
//   applied_duty  duty in effect for the current PWM period
//   pwm           PWM output
module motor_ramp_pwm #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] target,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] ramp_duty,
  output logic [PWM_BITS-1:0] applied_duty,
  output logic                pwm
);

  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

  logic [PWM_BITS-1:0] ramp_nxt;
  logic [PWM_BITS-1:0] applied_nxt;

  // Differences are taken in the safe direction so neither sum can wrap.
  always_comb begin
    ramp_nxt = ramp_duty;
    if (tick) begin
      if (ramp_duty < target) begin
        ramp_nxt = (target - ramp_duty > STEP) ? ramp_duty + STEP : target;
      end else if (ramp_duty > target) begin
        ramp_nxt = (ramp_duty - target > STEP) ? ramp_duty - STEP : target;
      end
    end
  end

  assign applied_nxt = (pwm_cnt == '0) ? ramp_duty : applied_duty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ramp_duty    <= '0;
      applied_duty <= '0;
      pwm          <= 1'b0;
    end else begin
      ramp_duty    <= ramp_nxt;
      applied_duty <= applied_nxt;
      pwm          <= (pwm_cnt < applied_nxt);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// motor_drive: two-channel DC motor driver behind the steering logic.
// Registers the steering inputs, decodes per-channel duty targets, runs the
// ramp prescaler and shared PWM counter, and sequences direction reversals
// through brake-to-zero and a dead time before the direction pins flip.
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    motor_drive_if slave: nav, dir_fwd in; pwm_l/r, dir_l/r,
//          moving, braking out
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned MAX_DUTY   = 200,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned RAMP_STEP  = 4,
  parameter int unsigned DEAD_TICKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  motor_drive_if.slave bus
);

  localparam int unsigned PRE_W  = $clog2(RAMP_DIV + 1);
  localparam int unsigned DEAD_W = $clog2(DEAD_TICKS + 1);
  localparam logic [PWM_BITS-1:0] MAX_D = PWM_BITS'(MAX_DUTY);

  logic [7:0]          nav_q;
  logic                dir_q;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  drive_state_e        state, state_nxt;
  logic [DEAD_W-1:0]   dead_cnt, dead_nxt;
  logic                dir_lat, dir_nxt;
  logic [PWM_BITS-1:0] tgt_l, tgt_r, tgt_l_nxt, tgt_r_nxt;
  logic [PWM_BITS-1:0] ramp_l, ramp_r, applied_l, applied_r;
  logic                pwm_l, pwm_r;
  logic                moving, braking;
  logic                all_zero;

  assign tick     = (pre_cnt == PRE_W'(RAMP_DIV - 1));
  assign all_zero = (ramp_l == '0) && (ramp_r == '0) &&
                    (applied_l == '0) && (applied_r == '0);

  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    dir_nxt   = dir_lat;
    case (state)
      ST_RUN: begin
        if (dir_q != dir_lat) state_nxt = ST_BRAKE;
      end
      ST_BRAKE: begin
        if (all_zero) begin
          state_nxt = ST_DEAD;
          dead_nxt  = '0;
        end
      end
      ST_DEAD: begin
        // The DEAD_TICKS-th tick ends the dead time; the direction latched
        // is whatever the switch says now, possibly the old direction.
        if (tick) begin
          if (dead_cnt == DEAD_W'(DEAD_TICKS - 1)) begin
            state_nxt = ST_RUN;
            dir_nxt   = dir_q;
          end else begin
            dead_nxt = dead_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Targets follow the upcoming state so braking forces zero immediately
  // and nav takes effect on the first RUN cycle after a reversal.
  always_comb begin
    tgt_l_nxt = '0;
    tgt_r_nxt = '0;
    if (state_nxt == ST_RUN) begin
      case (nav_q)
        NAV_PROCEED: begin tgt_l_nxt = MAX_D; tgt_r_nxt = MAX_D; end
        NAV_LEFT:    begin tgt_l_nxt = '0;    tgt_r_nxt = MAX_D; end
        NAV_RIGHT:   begin tgt_l_nxt = MAX_D; tgt_r_nxt = '0;    end
        default:     begin tgt_l_nxt = '0;    tgt_r_nxt = '0;    end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nav_q    <= NAV_STOP;
      dir_q    <= FWD;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      state    <= ST_RUN;
      dead_cnt <= '0;
      dir_lat  <= FWD;
      tgt_l    <= '0;
      tgt_r    <= '0;
      moving   <= 1'b0;
      braking  <= 1'b0;
    end else begin
      nav_q    <= bus.nav;
      dir_q    <= bus.dir_fwd;
      pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      dir_lat  <= dir_nxt;
      tgt_l    <= tgt_l_nxt;
      tgt_r    <= tgt_r_nxt;
      braking  <= (state_nxt != ST_RUN);
      // Applied duties load from the ramp duties only at cnt == 0, so
      // mirroring that load keeps moving aligned with the applied duty.
      if (pwm_cnt == '0) moving <= (ramp_l != '0) || (ramp_r != '0);
    end
  end

  motor_ramp_pwm #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP)
  ) u_left (
    .clk         (clk),
    .rst_n       (rst_n),
    .target      (tgt_l),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt),
    .ramp_duty   (ramp_l),
    .applied_duty(applied_l),
    .pwm         (pwm_l)
  );

  motor_ramp_pwm #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP)
  ) u_right (
    .clk         (clk),
    .rst_n       (rst_n),
    .target      (tgt_r),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt),
    .ramp_duty   (ramp_r),
    .applied_duty(applied_r),
    .pwm         (pwm_r)
  );

  assign bus.pwm_l   = pwm_l;
  assign bus.pwm_r   = pwm_r;
  assign bus.dir_l   = dir_lat;
  assign bus.dir_r   = dir_lat;
  assign bus.moving  = moving;
  assign bus.braking = braking;

endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed bench for motor_drive with a small configuration
// (PWM_BITS 4, MAX_DUTY 12, RAMP_DIV 2, RAMP_STEP 4, DEAD_TICKS 2).
module tb_motor_drive;
  import motor_drive_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic dir_prev = 1'b1;

  motor_drive_if bus ();

  motor_drive #(
    .PWM_BITS  (4),
    .MAX_DUTY  (12),
    .RAMP_DIV  (2),
    .RAMP_STEP (4),
    .DEAD_TICKS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic count_period(output int hl, output int hr);
    hl = 0;
    hr = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hl += int'(bus.pwm_l);
      hr += int'(bus.pwm_r);
    end
  endtask

  // Direction pins must never move while either motor is being driven.
  always @(negedge clk) begin
    if (rst_n && bus.dir_l !== dir_prev)
      chk("dir_flip_quiet", {31'b0, bus.pwm_l | bus.pwm_r}, 0);
    dir_prev = bus.dir_l;
  end

  initial begin
    int hl, hr, len;
    rst_n       = 1'b0;
    bus.nav     = 8'hFF;
    bus.dir_fwd = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm_l", bus.pwm_l, 0);
    chk("rst_pwm_r", bus.pwm_r, 0);
    chk("rst_dir_l", bus.dir_l, 1);
    chk("rst_dir_r", bus.dir_r, 1);
    chk("rst_moving", bus.moving, 0);
    chk("rst_braking", bus.braking, 0);

    // Proceed: ramp 0->4->8->12 at one step per 2 clks
    rst_n = 1'b1;
    for (int i = 0; i < 10 && dut.u_left.ramp_duty != 4'd4; i++) @(negedge clk);
    chk("up_l_4", dut.u_left.ramp_duty, 4);
    chk("up_r_4", dut.u_right.ramp_duty, 4);
    repeat (2) @(negedge clk);
    chk("up_l_8", dut.u_left.ramp_duty, 8);
    repeat (2) @(negedge clk);
    chk("up_l_12", dut.u_left.ramp_duty, 12);
    repeat (2) @(negedge clk);
    chk("up_l_sat", dut.u_left.ramp_duty, 12);
    chk("up_r_sat", dut.u_right.ramp_duty, 12);
    repeat (40) @(negedge clk);
    count_period(hl, hr);
    chk("fwd_hi_l", hl, 12);
    chk("fwd_hi_r", hr, 12);
    chk("fwd_moving", bus.moving, 1);
    chk("fwd_braking", bus.braking, 0);

    // Turn left: left ramps down, right holds
    bus.nav = 8'hF0;
    for (int i = 0; i < 10 && dut.u_left.ramp_duty != 4'd8; i++) @(negedge clk);
    chk("left_l_8", dut.u_left.ramp_duty, 8);
    repeat (2) @(negedge clk);
    chk("left_l_4", dut.u_left.ramp_duty, 4);
    repeat (2) @(negedge clk);
    chk("left_l_0", dut.u_left.ramp_duty, 0);
    chk("left_r_12", dut.u_right.ramp_duty, 12);
    repeat (32) @(negedge clk);
    count_period(hl, hr);
    chk("left_hi_l", hl, 0);
    chk("left_hi_r", hr, 12);
    chk("left_moving", bus.moving, 1);

    // Invalid pattern decodes as stop
    bus.nav = 8'h3C;
    repeat (40) @(negedge clk);
    chk("inv_r_0", dut.u_right.ramp_duty, 0);
    chk("inv_moving", bus.moving, 0);
    count_period(hl, hr);
    chk("inv_hi_l", hl, 0);
    chk("inv_hi_r", hr, 0);

    // Reversal from steady proceed
    bus.nav = 8'hFF;
    repeat (60) @(negedge clk);
    count_period(hl, hr);
    chk("pre_rev_hi_l", hl, 12);
    bus.dir_fwd = 1'b0;
    for (int i = 0; i < 5 && !bus.braking; i++) @(negedge clk);
    chk("rev_braking", bus.braking, 1);
    chk("rev_dir_hold", bus.dir_l, 1);
    for (int i = 0; i < 10 && dut.u_left.ramp_duty != 4'd8; i++) @(negedge clk);
    chk("rev_l_8", dut.u_left.ramp_duty, 8);
    repeat (2) @(negedge clk);
    chk("rev_l_4", dut.u_left.ramp_duty, 4);
    repeat (2) @(negedge clk);
    chk("rev_l_0", dut.u_left.ramp_duty, 0);
    chk("rev_r_0", dut.u_right.ramp_duty, 0);
    for (int i = 0; i < 40 && dut.state != ST_DEAD; i++) @(negedge clk);
    chk("rev_in_dead", int'(dut.state), int'(ST_DEAD));
    chk("dead_braking", bus.braking, 1);
    chk("dead_dir_hold", bus.dir_r, 1);
    len = 0;
    while (dut.state == ST_DEAD && len < 20) begin
      @(negedge clk);
      len++;
    end
    // Two ticks at one tick per 2 clks: 3 or 4 clks depending on phase
    chk("dead_len", {31'b0, (len >= 3 && len <= 4)}, 1);
    chk("rev_dir_l", bus.dir_l, 0);
    chk("rev_dir_r", bus.dir_r, 0);
    chk("rev_run_braking", bus.braking, 0);
    repeat (60) @(negedge clk);
    count_period(hl, hr);
    chk("rev_hi_l", hl, 12);
    chk("rev_hi_r", hr, 12);

    // Reset mid-ramp (duty 8) while reversed
    bus.nav = 8'h00;
    for (int i = 0; i < 10 && dut.u_left.ramp_duty != 4'd8; i++) @(negedge clk);
    chk("mid_l_8", dut.u_left.ramp_duty, 8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_dir_l", bus.dir_l, 1);
    chk("mr_dir_r", bus.dir_r, 1);
    chk("mr_pwm_l", bus.pwm_l, 0);
    chk("mr_moving", bus.moving, 0);
    chk("mr_braking", bus.braking, 0);
    chk("mr_ramp_l", dut.u_left.ramp_duty, 0);
    chk("mr_state", int'(dut.state), int'(ST_RUN));

    // Release with dir_fwd = 0: immediate brake, then DEAD; reset mid-DEAD
    rst_n = 1'b1;
    for (int i = 0; i < 10 && dut.state != ST_DEAD; i++) @(negedge clk);
    chk("rel_rev_dead", int'(dut.state), int'(ST_DEAD));
    rst_n = 1'b0;
    @(negedge clk);
    chk("md_state", int'(dut.state), int'(ST_RUN));
    chk("md_braking", bus.braking, 0);
    chk("md_dir_l", bus.dir_l, 1);
    chk("md_moving", bus.moving, 0);

    // Release again and let the reversal complete
    rst_n = 1'b1;
    bus.nav = 8'hFF;
    for (int i = 0; i < 20 && bus.dir_l != 1'b0; i++) @(negedge clk);
    chk("rel_rev_dir_l", bus.dir_l, 0);
    chk("rel_rev_state", int'(dut.state), int'(ST_RUN));
    repeat (60) @(negedge clk);
    count_period(hl, hr);
    chk("rel_rev_hi_l", hl, 12);
    chk("rel_rev_hi_r", hr, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
